// File: rtl/fir_frame_buffer.sv
// fir_frame_buffer: two-bank ping-pong buffer that frames the FIR stream and replays
// each frame to the FFT over valid/ready, in bit-reversed or natural order.
module fir_frame_buffer #(
  parameter int N = 16,
  parameter int LOG2N = 4,
  parameter int DW = 16,
  parameter bit BITREV = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fir_valid,
  input  logic [DW-1:0]    fir_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [LOG2N-1:0] out_idx,
  output logic             out_last,
  output logic             overflow,
  output logic [7:0]       frame_cnt
);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
  logic [DW-1:0] mem [2*N];
  logic [1:0] full;
  logic wbank, rbank, wr, rd;
  logic [LOG2N-1:0] wptr, rptr, rev, raddr;
  for (genvar i = 0; i < LOG2N; i++) begin : g_rev
    assign rev[i] = rptr[LOG2N-1-i];
  end
  always_comb begin
    wr = fir_valid && !full[wbank];
    rd = out_valid && out_ready;
    raddr = BITREV ? rev : rptr;
  end
  assign out_valid = full[rbank];
  assign out_data = out_valid ? mem[{rbank, raddr}] : '0;
  assign out_idx = rptr;
  assign out_last = out_valid && rptr == LAST;
  always_ff @(posedge clk)
    if (wr) mem[{wbank, wptr}] <= fir_d;
  // writer and reader never target the same full bit: the writer only touches an empty bank
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      overflow <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (fir_valid && full[wbank]) overflow <= 1'b1;
      if (wr) begin
        wptr <= wptr + 1'b1;
        if (wptr == LAST) begin
          full[wbank] <= 1'b1;
          wbank <= ~wbank;
        end
      end
      if (rd) begin
        rptr <= rptr + 1'b1;
        if (rptr == LAST) begin
          full[rbank] <= 1'b0;
          rbank <= ~rbank;
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fir_frame_buffer.sv
// tb_fir_frame_buffer: frame-level reference model feeding a scoreboard that checks
// a bit-reversed and a natural-order instance side by side.
module tb_fir_frame_buffer;
  localparam int N = 16;
  logic clk = 1'b0, rst = 1'b1, fir_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] fir_d = '0;
  logic ov [2];
  logic ol [2];
  logic of [2];
  logic [15:0] od [2];
  logic [3:0] oi [2];
  logic [7:0] fc [2];
  int n_chk = 0, n_fail = 0;
  bit go = 1'b0;
  logic [19:0] q0 [$];
  logic [19:0] q1 [$];
  logic [15:0] part [$];
  int pend = 0, rcnt = 0;
  logic m_ovf = 1'b0;
  logic [7:0] m_fc = '0;

  fir_frame_buffer #(.N(N), .LOG2N(4), .DW(16), .BITREV(1'b1)) dut_br (
    .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_idx(oi[0]),
    .out_last(ol[0]), .overflow(of[0]), .frame_cnt(fc[0]));
  fir_frame_buffer #(.N(N), .LOG2N(4), .DW(16), .BITREV(1'b0)) dut_nat (
    .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_idx(oi[1]),
    .out_last(ol[1]), .overflow(of[1]), .frame_cnt(fc[1]));

  always #5 clk = ~clk;

  function automatic int br(int x);
    int r = 0;
    for (int i = 0; i < 4; i++) r |= ((x >> i) & 1) << (3 - i);
    return r;
  endfunction

  task automatic cmp(input string nm, input int k, input logic [31:0] a, input logic [31:0] b);
    n_chk++;
    if (a !== b) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t got %0h want %0h", nm, k, $time, a, b);
    end
  endtask

  // Frames are modelled as whole units: up to two complete frames can wait for the reader.
  function automatic void model(input logic r_st, input logic v, input logic [15:0] d, input logic r);
    bit drop, racc;
    if (r_st) begin
      q0.delete(); q1.delete(); part.delete();
      pend = 0; rcnt = 0; m_ovf = 1'b0; m_fc = '0;
      return;
    end
    drop = v && pend == 2;
    racc = r && pend > 0;
    if (drop) m_ovf = 1'b1;
    if (racc) begin
      rcnt++;
      if (rcnt == N) begin
        rcnt = 0; pend--; m_fc = m_fc + 8'd1;
      end
    end
    if (v && !drop) begin
      part.push_back(d);
      if (part.size() == N) begin
        pend++;
        for (int p = 0; p < N; p++) begin
          q0.push_back({4'(p), part[br(p)]});
          q1.push_back({4'(p), part[p]});
        end
        part.delete();
      end
    end
  endfunction

  task automatic step(input logic r_st, input logic v, input logic [15:0] d, input logic r);
    rst = r_st; fir_valid = v; fir_d = d; out_ready = r;
    @(posedge clk);
    model(r_st, v, d, r);
    #1;
  endtask

  task automatic chk(input int k);
    int sz;
    logic [19:0] e;
    sz = k ? q1.size() : q0.size();
    cmp("out_valid", k, 32'(ov[k]), 32'(sz > 0));
    if (sz > 0) begin
      e = k ? q1[0] : q0[0];
      cmp("out_data", k, 32'(od[k]), 32'(e[15:0]));
      cmp("out_idx", k, 32'(oi[k]), 32'(e[19:16]));
      cmp("out_last", k, 32'(ol[k]), 32'(e[19:16] == 4'd15));
      if (out_ready) begin
        if (k) void'(q1.pop_front()); else void'(q0.pop_front());
      end
    end else begin
      cmp("idle_data", k, 32'(od[k]), 32'd0);
      cmp("idle_idx", k, 32'(oi[k]), 32'd0);
      cmp("idle_last", k, 32'(ol[k]), 32'd0);
    end
    cmp("overflow", k, 32'(of[k]), 32'(m_ovf));
    cmp("frame_cnt", k, 32'(fc[k]), 32'(m_fc));
  endtask

  always @(negedge clk)
    if (go) begin
      chk(0);
      chk(1);
    end

  task automatic drain(input bit toggle);
    for (int i = 0; i < 200 && q0.size() > 0; i++) step(1'b0, 1'b0, 16'd0, toggle ? 1'(i) : 1'b1);
    cmp("drain_timeout", 0, 32'(q0.size()), 32'd0);
    step(1'b0, 1'b0, 16'd0, 1'b1);
  endtask

  initial begin
    step(1'b1, 1'b1, 16'h1234, 1'b1);
    go = 1'b1;
    step(1'b1, 1'b1, 16'h5678, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'(i), 1'b1);
    drain(1'b0);
    for (int i = 0; i < 48; i++) step(1'b0, 1'b1, 16'(i), 1'b1);
    drain(1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 16'(i), 1'b0);
    drain(1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'(200 + i), 1'b0);
    drain(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'(50 + i), 1'b1);
    step(1'b1, 1'b0, 16'd0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'(100 + i), 1'b1);
    drain(1'b0);
    for (int i = 0; i < 600; i++)
      step(1'b0, $urandom_range(0, 9) < 8, 16'($urandom), $urandom_range(0, 3) != 0);
    drain(1'b0);
    step(1'b1, 1'b1, 16'd7, 1'b1);
    step(1'b0, 1'b0, 16'd0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
